// File: rtl/xboot.sv
// Boot loader: streams BOOT_LEN words from a handshaked source into program
// memory, verifies an XOR checksum word, then releases the processor reset.
`ifndef PROG_ADDR_W
`define PROG_ADDR_W 8
`endif
`ifndef INSTR_W
`define INSTR_W 16
`endif
`ifndef PROG_ROM
`define PROG_ROM 0
`endif

module xboot #(
  parameter int                     PROG_ADDR_W = `PROG_ADDR_W,
  parameter int                     INSTR_W     = `INSTR_W,
  parameter int                     BOOT_LEN    = 256,
  parameter logic [PROG_ADDR_W-1:0] BOOT_BASE   = PROG_ADDR_W'(`PROG_ROM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   boot_req,
  input  logic                   boot_bypass,
  output logic                   src_req,
  input  logic                   src_ack,
  input  logic [INSTR_W-1:0]     src_data,
  output logic                   prog_we,
  output logic [PROG_ADDR_W-1:0] prog_addr,
  output logic [INSTR_W-1:0]     prog_data,
  output logic                   cpu_rst,
  output logic                   boot_done,
  output logic                   boot_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  // Counter only has to reach BOOT_LEN-1, which fits PROG_ADDR_W bits.
  localparam logic [PROG_ADDR_W-1:0] LAST_IDX = PROG_ADDR_W'(BOOT_LEN - 1);

  logic [2:0]             state_reg;
  logic [2:0]             state_next;
  logic [PROG_ADDR_W-1:0] count_reg;
  logic [PROG_ADDR_W-1:0] count_next;
  logic [INSTR_W-1:0]     acc_reg;
  logic [INSTR_W-1:0]     acc_next;
  logic                   xfer;
  logic                   write_next;

  // src_req is itself registered, so a transfer is fully qualified by it.
  assign xfer       = src_req & src_ack;
  assign write_next = (state_reg == S_LOAD) & xfer;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    acc_next   = acc_reg;
    case (state_reg)
      S_IDLE: begin
        if (boot_bypass) begin
          state_next = S_RUN;
        end else begin
          state_next = S_LOAD;
          count_next = '0;
          acc_next   = '0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          count_next = count_reg + 1'b1;
          acc_next   = acc_reg ^ src_data;
          if (count_reg == LAST_IDX) begin
            state_next = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          state_next = (src_data == acc_reg) ? S_RUN : S_ERROR;
        end
      end
      S_RUN, S_ERROR: begin
        if (boot_req) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so they line up with the state
  // they describe; cpu_rst therefore drops in the first RUN cycle, which is
  // never earlier than the cycle after the final program write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      acc_reg   <= '0;
      src_req   <= 1'b0;
      prog_we   <= 1'b0;
      prog_addr <= BOOT_BASE;
      prog_data <= '0;
      cpu_rst   <= 1'b1;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      acc_reg   <= acc_next;
      src_req   <= (state_next == S_LOAD) | (state_next == S_CHECK);
      prog_we   <= write_next;
      if (write_next) begin
        prog_addr <= BOOT_BASE + count_reg;
        prog_data <= src_data;
      end
      cpu_rst   <= (state_next != S_RUN);
      boot_done <= (state_next == S_RUN);
      boot_err  <= (state_next == S_ERROR);
    end
  end

endmodule

// File: tb/tb_xboot.sv
// Self-checking bench for xboot: per-cycle comparison against a transaction
// level model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps

module tb_xboot;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int LEN  = 4;
  localparam int BASE = 254;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          boot_req = 1'b0;
  logic          boot_bypass = 1'b0;
  logic          src_req;
  logic          src_ack = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          cpu_rst;
  logic          boot_done;
  logic          boot_err;

  xboot #(
    .PROG_ADDR_W(AW),
    .INSTR_W(DW),
    .BOOT_LEN(LEN),
    .BOOT_BASE(8'(BASE))
  ) dut (
    .clk(clk),
    .rst(rst),
    .boot_req(boot_req),
    .boot_bypass(boot_bypass),
    .src_req(src_req),
    .src_ack(src_ack),
    .src_data(src_data),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .cpu_rst(cpu_rst),
    .boot_done(boot_done),
    .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: phase 0 idle, 1 fetching (payload then checksum), 2 run, 3 error.
  int            m_phase = 0;
  int            m_taken = 0;
  logic [DW-1:0] m_acc = '0;
  logic          e_we = 1'b0;
  logic [AW-1:0] e_addr = 8'(BASE);
  logic [DW-1:0] e_data = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_taken = 0;
      m_acc   = '0;
      e_we    = 1'b0;
      e_addr  = 8'(BASE);
      e_data  = '0;
    end else begin
      cyc++;
      e_we = 1'b0;
      case (m_phase)
        0: begin
          if (boot_bypass) m_phase = 2;
          else begin
            m_phase = 1;
            m_taken = 0;
            m_acc   = '0;
          end
        end
        1: begin
          if (src_ack) begin
            if (m_taken < LEN) begin
              e_we    = 1'b1;
              e_addr  = 8'((BASE + m_taken) % 256);
              e_data  = src_data;
              m_acc   = m_acc ^ src_data;
              m_taken = m_taken + 1;
            end else begin
              m_phase = (src_data == m_acc) ? 2 : 3;
            end
          end
        end
        default: if (boot_req) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("src_req",   32'(src_req),   32'(m_phase == 1));
    chk("prog_we",   32'(prog_we),   32'(e_we));
    chk("prog_addr", 32'(prog_addr), 32'(e_addr));
    chk("prog_data", 32'(prog_data), 32'(e_data));
    chk("cpu_rst",   32'(cpu_rst),   32'(m_phase != 2));
    chk("boot_done", 32'(boot_done), 32'(m_phase == 2));
    chk("boot_err",  32'(boot_err),  32'(m_phase == 3));
  end

  // Observation log for the directed scenarios.
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            wc_q[$];
  int            fall_cyc = -1;
  logic          prev_cpu_rst = 1'b1;
  logic          src_seen = 1'b0;

  always @(negedge clk) begin
    if (prog_we) begin
      wa_q.push_back(prog_addr);
      wd_q.push_back(prog_data);
      wc_q.push_back(cyc);
    end
    if (prev_cpu_rst && !cpu_rst) fall_cyc = cyc;
    prev_cpu_rst = cpu_rst;
    if (src_req) src_seen = 1'b1;
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    fall_cyc = -1;
    src_seen = 1'b0;
  endtask

  task automatic pulse_req(input logic bypass);
    @(negedge clk);
    boot_req    = 1'b1;
    boot_bypass = bypass;
    @(negedge clk);
    boot_req    = 1'b0;
    @(negedge clk);
    boot_bypass = 1'b0;
  endtask

  // mode 0: ack always; mode 1: ack pattern 1,0,0; mode 2: random ack/noise
  task automatic run_boot(input logic [DW-1:0] w0, w1, w2, w3, csum, input int mode);
    logic [DW-1:0] w [4];
    int idx = 0;
    int n = 0;
    logic x;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    while (idx < 5 && n < 200) begin
      @(negedge clk);
      case (mode)
        0: src_ack = 1'b1;
        1: src_ack = ((n % 3) == 0);
        default: begin
          src_ack     = 1'($urandom_range(0, 1));
          boot_req    = ($urandom_range(0, 3) == 0);
          boot_bypass = 1'($urandom_range(0, 1));
        end
      endcase
      if (!src_ack) src_data = 8'($urandom);
      else src_data = (idx < 4) ? w[idx] : csum;
      x = src_req & src_ack;
      @(posedge clk);
      if (x) idx++;
      n++;
    end
    @(negedge clk);
    src_ack     = 1'b0;
    boot_req    = 1'b0;
    boot_bypass = 1'b0;
    chk("boot_timeout", 32'(idx), 32'd5);
  endtask

  initial begin
    logic [AW-1:0] exp_a [4];
    logic [DW-1:0] exp_d [4];
    logic [DW-1:0] r [4];
    logic [DW-1:0] cs;
    int            cnt;
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h44; exp_d[3] = 8'h88;

    repeat (3) @(negedge clk);
    chk("rst_src_req", 32'(src_req), 32'd0);
    chk("rst_prog_we", 32'(prog_we), 32'd0);
    chk("rst_addr",    32'(prog_addr), 32'hFE);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done",    32'(boot_done), 32'd0);
    clear_log();
    rst = 1'b0;

    // Back-to-back load with correct checksum; addresses wrap past 0xFF.
    run_boot(8'h11, 8'h22, 8'h44, 8'h88, 8'hFF, 0);
    repeat (2) @(negedge clk);
    chk("a_nwrites", 32'(wa_q.size()), 32'd4);
    if (wa_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("a_addr", 32'(wa_q[i]), 32'(exp_a[i]));
        chk("a_data", 32'(wd_q[i]), 32'(exp_d[i]));
        chk("a_consec", 32'(wc_q[i]), 32'(wc_q[0] + i));
      end
      chk("a_cpu_rst_fall", 32'(fall_cyc), 32'(wc_q[3] + 1));
    end
    chk("a_done", 32'(boot_done), 32'd1);

    // Bad checksum goes to ERROR and keeps the processor in reset.
    pulse_req(1'b0);
    run_boot(8'h11, 8'h22, 8'h44, 8'h88, 8'hFE, 0);
    repeat (2) @(negedge clk);
    chk("b_err", 32'(boot_err), 32'd1);
    chk("b_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("b_done", 32'(boot_done), 32'd0);

    // Reload with sparse acks: addresses contiguous from base, no duplicates.
    clear_log();
    pulse_req(1'b0);
    run_boot(8'h11, 8'h22, 8'h44, 8'h88, 8'hFF, 1);
    repeat (2) @(negedge clk);
    chk("c_nwrites", 32'(wa_q.size()), 32'd4);
    if (wa_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("c_addr", 32'(wa_q[i]), 32'(exp_a[i]));
    end
    chk("c_done", 32'(boot_done), 32'd1);

    // Bypass: straight to RUN, source never requested, nothing written.
    clear_log();
    pulse_req(1'b1);
    repeat (3) @(negedge clk);
    chk("d_nwrites", 32'(wa_q.size()), 32'd0);
    chk("d_src_seen", 32'(src_seen), 32'd0);
    chk("d_done", 32'(boot_done), 32'd1);

    // Asynchronous reset between edges right after word 2 is captured.
    pulse_req(1'b0);
    cnt = 0;
    for (int n = 0; n < 50 && cnt < 2; n++) begin
      @(negedge clk);
      src_ack  = 1'b1;
      src_data = exp_d[cnt];
      if (src_req) cnt++;
      @(posedge clk);
    end
    #3 rst = 1'b1;
    #1;
    chk("e_prog_we", 32'(prog_we), 32'd0);
    chk("e_src_req", 32'(src_req), 32'd0);
    chk("e_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("e_addr",    32'(prog_addr), 32'hFE);
    @(negedge clk);
    src_ack = 1'b0;
    clear_log();
    rst = 1'b0;
    run_boot(8'h11, 8'h22, 8'h44, 8'h88, 8'hFF, 0);
    repeat (2) @(negedge clk);
    chk("e_nwrites", 32'(wa_q.size()), 32'd4);
    if (wa_q.size() == 4) chk("e_first_addr", 32'(wa_q[0]), 32'hFE);
    chk("e_done", 32'(boot_done), 32'd1);

    // Randomized boots, all checked cycle by cycle against the model.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        pulse_req(1'b1);
      end else begin
        pulse_req(1'b0);
        for (int k = 0; k < 4; k++) r[k] = 8'($urandom);
        cs = r[0] ^ r[1] ^ r[2] ^ r[3];
        if ($urandom_range(0, 2) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
        run_boot(r[0], r[1], r[2], r[3], cs, int'($urandom_range(0, 2)));
      end
      repeat (2) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xboot.md
XBOOT -- requirements
Module: xboot

Interface
REQ-001 Parameter PROG_ADDR_W, default `PROG_ADDR_W: program memory address width.
REQ-002 Parameter INSTR_W, default `INSTR_W: instruction word width.
REQ-003 Parameter BOOT_LEN, default 256: payload words per boot, range 1..2^PROG_ADDR_W.
REQ-004 Parameter BOOT_BASE, default `PROG_ROM: first program memory address written.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 boot_req  input  1  restart request, honoured in RUN and ERROR only.
REQ-008 boot_bypass  input  1  sampled in IDLE: 1 skips loading.
REQ-009 src_req  output  1  word request to boot source.
REQ-010 src_ack  input  1  source handshake; word transfers on any cycle with src_req=1 and src_ack=1.
REQ-011 src_data  input  INSTR_W  source word, valid when src_ack=1.
REQ-012 prog_we  output  1  program memory write enable.
REQ-013 prog_addr  output  PROG_ADDR_W  program memory write address.
REQ-014 prog_data  output  INSTR_W  program memory write data.
REQ-015 cpu_rst  output  1  reset driven to the processor controller, active-high.
REQ-016 boot_done  output  1  high in RUN.
REQ-017 boot_err  output  1  high in ERROR.

Function
REQ-018 States IDLE, LOAD, CHECK, RUN, ERROR; every output is registered.
REQ-019 IDLE: one cycle; boot_bypass=1 -> RUN; otherwise -> LOAD with word counter and checksum accumulator cleared.
REQ-020 LOAD: src_req=1 continuously; back-to-back acks accepted, one word per cycle, no bubbles.
REQ-021 Per LOAD transfer: prog_we=1 exactly in the following cycle with prog_addr=BOOT_BASE+count (modulo 2^PROG_ADDR_W) and prog_data=captured word.
REQ-022 Per LOAD transfer: counter increments by 1 and accumulator becomes accumulator XOR src_data.
REQ-023 Transfer of word BOOT_LEN-1 moves LOAD -> CHECK; src_req stays 1 with no gap.
REQ-024 CHECK: the next transfer is the checksum word; it is not written to program memory (prog_we stays 0).
REQ-025 Checksum equal to the accumulator -> RUN; otherwise -> ERROR.
REQ-026 src_req=0 in IDLE, RUN and ERROR; src_ack in those states is ignored.
REQ-027 cpu_rst=1 in IDLE, LOAD, CHECK and ERROR; cpu_rst=0 only in RUN.
REQ-028 cpu_rst deasserts one cycle after the last prog_we pulse, so no instruction fetch can precede completion of the final write.
REQ-029 boot_req=1 in RUN or ERROR -> IDLE next cycle: cpu_rst=1, boot_done=0, boot_err=0.
REQ-030 boot_req is ignored in IDLE, LOAD and CHECK.
REQ-031 src_ack held low indefinitely: state, counter and outputs are held, with no timeout.
REQ-032 boot_bypass is ignored outside IDLE.

Reset
REQ-033 rst=1 forces IDLE asynchronously, with no clock edge required.
REQ-034 Reset values: src_req=0, prog_we=0, prog_addr=BOOT_BASE, prog_data=0, cpu_rst=1, boot_done=0, boot_err=0, counter=0, accumulator=0.
REQ-035 rst asserted mid-LOAD or mid-CHECK aborts the boot; a captured but unwritten word is discarded (no prog_we).
REQ-036 After rst deasserts, boot restarts from IDLE.

Verification
REQ-037 BOOT_LEN=4, src_ack constantly 1, words 0x11,0x22,0x44,0x88, checksum 0xFF -> four consecutive prog_we pulses at BOOT_BASE..BOOT_BASE+3, then RUN; cpu_rst falls one cycle after the last write; boot_done=1.
REQ-038 Same stream with checksum 0xFE -> ERROR; boot_err=1, cpu_rst stays 1; boot_req pulse -> IDLE, then a fresh load reuses BOOT_BASE.
REQ-039 src_ack toggling 1,0,0,1,... -> prog_we pulses only after acked cycles; addresses stay contiguous, with no duplicates and no skips.
REQ-040 boot_bypass=1 at reset release -> RUN after the IDLE cycle, src_req never asserted, prog_we never asserted.
REQ-041 rst asserted asynchronously between edges after word 2 of 4 -> outputs take reset values immediately; after release the load restarts at BOOT_BASE and completes correctly.
REQ-042 BOOT_BASE=2^PROG_ADDR_W-2, BOOT_LEN=4 -> write addresses wrap: 2^PROG_ADDR_W-2, 2^PROG_ADDR_W-1, 0, 1.
